div_unit: RTL and testbench

Iterative radix-2 integer divide unit for the RV64 execute stage. It implements DIV, DIVU, REM and REMU and their W variants. It takes the same operand/word-op interface as the single-cycle ALU path, but uses a valid/ready request/response handshake because it needs many cycles per operation. It sits beside the ALU and returns its result to the execute-stage writeback mux.

---
 rtl/div_unit_if.sv | 28 ++
 rtl/div_unit.sv | 175 +++++++++++++++++
 tb/tb_div_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divide unit.
// master drives requests and consumes results; slave is the divider.
interface div_unit_if #(
    parameter int XLEN = 64
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [XLEN-1:0] opr_a_i;
    logic [XLEN-1:0] opr_b_i;
    logic [1:0]      div_func_i;
    logic            word_op_i;
    logic            flush_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [XLEN-1:0] div_res_o;

    modport master (
        output req_valid_i, opr_a_i, opr_b_i, div_func_i,
        output word_op_i, flush_i, res_ready_i,
        input  req_ready_o, res_valid_o, div_res_o
    );

    modport slave (
        input  req_valid_i, opr_a_i, opr_b_i, div_func_i,
        input  word_op_i, flush_i, res_ready_i,
        output req_ready_o, res_valid_o, div_res_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and W forms.
// DIV_FAST_SPECIAL_EN: divide-by-zero and overflow skip straight to DONE.
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            remop_q, remop_d;
    logic            word_q, word_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;

    function automatic logic [XLEN-1:0] wsext(
        input logic [XLEN-1:0] v,
        input logic            w
    );
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic [XLEN-1:0] special(
        input logic [XLEN-1:0] a,
        input logic            r,
        input logic            dz
    );
        if (dz) return r ? a : '1;
        return r ? '0 : a;
    endfunction

    logic            sgn_in, sa_in, sb_in, dz_in, ovf_in, accept;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;

    assign sgn_in = ~bus.div_func_i[0];
    assign a_ext  = bus.word_op_i
                  ? {{(XLEN-32){sgn_in & bus.opr_a_i[31]}}, bus.opr_a_i[31:0]}
                  : bus.opr_a_i;
    assign b_ext  = bus.word_op_i
                  ? {{(XLEN-32){sgn_in & bus.opr_b_i[31]}}, bus.opr_b_i[31:0]}
                  : bus.opr_b_i;
    assign sa_in  = sgn_in & a_ext[XLEN-1];
    assign sb_in  = sgn_in & b_ext[XLEN-1];
    assign mag_a  = sa_in ? -a_ext : a_ext;
    assign mag_b  = sb_in ? -b_ext : b_ext;
    assign dz_in  = (b_ext == '0);
    // Most-negative dividend is the sign-extended 32-bit one for W ops.
    assign ovf_in = sgn_in & (&b_ext) & (bus.word_op_i
                  ? (a_ext == {{(XLEN-31){1'b1}}, 31'b0})
                  : (a_ext == {1'b1, {(XLEN-1){1'b0}}}));

    assign bus.req_ready_o = (state_q == IDLE) && !bus.flush_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign bus.res_valid_o = valid_q;
    assign bus.div_res_o   = res_q;

    logic [XLEN:0]   rem_sh, diff;
    logic            fits;
    logic [XLEN-1:0] q_full, q_sgn, r_sgn, fix_raw;

    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvs_q};
    assign fits    = ~diff[XLEN];
    assign q_full  = word_q ? {{(XLEN-32){1'b0}}, quo_q[31:0]} : quo_q;
    assign q_sgn   = negq_q ? -q_full : q_full;
    assign r_sgn   = negr_q ? -rem_q : rem_q;
    assign fix_raw = (dz_q | ovf_q) ? special(dvd_q, remop_q, dz_q)
                   : (remop_q ? r_sgn : q_sgn);

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        remop_d = remop_q;
        word_d  = word_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: if (accept) begin
                // W dividends start left-aligned so 32 shifts consume them.
                quo_d   = bus.word_op_i ? {mag_a[31:0], 32'b0} : mag_a;
                rem_d   = '0;
                dvs_d   = mag_b;
                dvd_d   = a_ext;
                cnt_d   = bus.word_op_i ? 7'd31 : 7'd63;
                negq_d  = sa_in ^ sb_in;
                negr_d  = sa_in;
                remop_d = bus.div_func_i[1];
                word_d  = bus.word_op_i;
                dz_d    = dz_in;
                ovf_d   = ovf_in;
                state_d = CALC;
`ifdef DIV_FAST_SPECIAL_EN
                if (dz_in | ovf_in) begin
                    res_d   = wsext(special(a_ext, bus.div_func_i[1], dz_in),
                                    bus.word_op_i);
                    valid_d = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            CALC: begin
                quo_d = {quo_q[XLEN-2:0], fits};
                rem_d = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd0) state_d = FIX;
            end
            FIX: begin
                res_d   = wsext(fix_raw, word_q);
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: if (bus.res_ready_i) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        if (bus.flush_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            remop_q <= 1'b0;
            word_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            remop_q <= remop_d;
            word_q  <= word_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors queued at issue,
// checked by an independent monitor when res_valid_o rises.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_unit_if ifc ();
    div_unit dut (.clk(clk), .rst(rst), .bus(ifc.slave));

`ifdef DIV_FAST_SPECIAL_EN
    localparam int LS64 = 1;
    localparam int LS32 = 1;
`else
    localparam int LS64 = 66;
    localparam int LS32 = 34;
`endif

    typedef struct {
        logic [63:0] res;
        int          t;
        int          lat;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_id = 0;
    logic got = 1'b0;
    logic anyval = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            got = 1'b0;
        end else if (ifc.res_valid_o) begin
            anyval = 1'b1;
            if (!got) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got %h", ifc.div_res_o);
                    cur.res = ifc.div_res_o;
                    cur.t   = cyc;
                    cur.lat = 0;
                    cur.id  = -1;
                end else begin
                    cur = sb.pop_front();
                    checks += 2;
                    if (ifc.div_res_o !== cur.res) begin
                        errors++;
                        $display("FAIL result_%0d got %h exp %h",
                                 cur.id, ifc.div_res_o, cur.res);
                    end
                    if (cyc - cur.t != cur.lat) begin
                        errors++;
                        $display("FAIL latency_%0d got %0d exp %0d",
                                 cur.id, cyc - cur.t, cur.lat);
                    end
                end
            end else begin
                checks++;
                if (ifc.div_res_o !== cur.res) begin
                    errors++;
                    $display("FAIL hold_stable_%0d got %h exp %h",
                             cur.id, ifc.div_res_o, cur.res);
                end
            end
        end else begin
            got = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ifc.req_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got 0 exp 1");
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] f, input logic w,
                         input logic [63:0] e, input int lat);
        exp_t x;
        int n;
        @(negedge clk);
        wait_ready();
        ifc.opr_a_i     = a;
        ifc.opr_b_i     = b;
        ifc.div_func_i  = f;
        ifc.word_op_i   = w;
        ifc.req_valid_i = 1'b1;
        x.res = e;
        x.t   = cyc;
        x.lat = lat;
        x.id  = next_id;
        next_id++;
        sb.push_back(x);
        @(negedge clk);
        ifc.req_valid_i = 1'b0;
        ifc.opr_a_i     = {$urandom, $urandom};
        ifc.opr_b_i     = {$urandom, $urandom};
        ifc.div_func_i  = 2'($urandom);
        ifc.word_op_i   = 1'($urandom);
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout got none exp %h", e);
            sb.delete();
        end
    endtask

    initial begin
        ifc.req_valid_i = 1'b0;
        ifc.opr_a_i     = '0;
        ifc.opr_b_i     = '0;
        ifc.div_func_i  = 2'b00;
        ifc.word_op_i   = 1'b0;
        ifc.flush_i     = 1'b0;
        ifc.res_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'b0, ifc.res_valid_o}, 64'd0);
        chk("rst_res", ifc.div_res_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {63'b0, ifc.req_ready_o}, 64'd1);

        issue(64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 66);
        issue(64'd100, 64'd7, 2'b11, 1'b0, 64'd2, 66);
        issue(-64'sd7, 64'd2, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFFFD, 66);
        issue(-64'sd7, 64'd2, 2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFF, 66);
        issue(64'd7, -64'sd2, 2'b10, 1'b0, 64'd1, 66);
        issue(64'd5, 64'd0, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFFFF, LS64);
        issue(64'd5, 64'd0, 2'b11, 1'b0, 64'd5, LS64);
        issue(64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 2'b00, 1'b0,
              64'h8000000000000000, LS64);
        issue(64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 2'b10, 1'b0,
              64'd0, LS64);
        issue(64'h0000000080000000, 64'h00000000FFFFFFFF, 2'b00, 1'b1,
              64'hFFFFFFFF80000000, LS32);
        issue(64'hABCD0000FFFFFFFE, 64'd1, 2'b01, 1'b1,
              64'hFFFFFFFFFFFFFFFE, 34);
        issue(64'h00000000FFFFFFF9, 64'd2, 2'b10, 1'b1,
              64'hFFFFFFFFFFFFFFFF, 34);
        issue(64'h1234567880000005, 64'hFFFFFFFF00000000, 2'b11, 1'b1,
              64'hFFFFFFFF80000005, LS32);

        // Consumer stalls: result must stay put while DONE persists.
        ifc.res_ready_i = 1'b0;
        issue(64'd1000, 64'd10, 2'b01, 1'b0, 64'd100, 66);
        repeat (20) @(negedge clk);
        chk("hold_valid", {63'b0, ifc.res_valid_o}, 64'd1);
        chk("hold_res", ifc.div_res_o, 64'd100);
        ifc.res_ready_i = 1'b1;
        @(negedge clk);
        chk("hold_release", {63'b0, ifc.res_valid_o}, 64'd0);

        // Flush at CALC iteration 10.
        wait_ready();
        anyval          = 1'b0;
        ifc.opr_a_i     = 64'd1000;
        ifc.opr_b_i     = 64'd3;
        ifc.div_func_i  = 2'b01;
        ifc.word_op_i   = 1'b0;
        ifc.req_valid_i = 1'b1;
        @(negedge clk);
        ifc.req_valid_i = 1'b0;
        repeat (9) @(negedge clk);
        ifc.flush_i = 1'b1;
        @(negedge clk);
        ifc.flush_i = 1'b0;
        #1;
        chk("flush_ready", {63'b0, ifc.req_ready_o}, 64'd1);
        repeat (80) @(negedge clk);
        chk("flush_noval", {63'b0, anyval}, 64'd0);

        // Reset pulse mid-CALC.
        wait_ready();
        ifc.opr_a_i     = 64'd12345;
        ifc.opr_b_i     = 64'd7;
        ifc.div_func_i  = 2'b01;
        ifc.req_valid_i = 1'b1;
        @(negedge clk);
        ifc.req_valid_i = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", {63'b0, ifc.res_valid_o}, 64'd0);
        chk("midrst_res", ifc.div_res_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(64'd9, 64'd3, 2'b01, 1'b0, 64'd3, 66);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
